// File: rtl/weight_axi_ctrl_if.sv
// AXI4-Lite host port of weight_axi_ctrl: slave modport for the controller,
// master modport for whatever drives it.
interface weight_axi_ctrl_if;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
               s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
               s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/weight_axi_ctrl.sv
// AXI4-Lite slave mapping (source, destination) spin addresses onto coupling-matrix
// columns. Define WEIGHT_READBACK_EN to return column read data; otherwise reads return 0.
module weight_axi_ctrl #(
    parameter int N           = 8,
    parameter int NUM_COLS    = N - 1,
    parameter int RD_WAIT_CYC = 2
) (
    input  logic                   clk,
    input  logic                   axi_rstn,
    weight_axi_ctrl_if.slave       axi,
    output logic                   col_wready,
    output logic [NUM_COLS-1:0]    col_wr_match,
    output logic [15:0]            s_addr,
    output logic [15:0]            d_addr,
    output logic [31:0]            col_wdata,
    input  logic [32*NUM_COLS-1:0] col_rdata
);
    localparam int            CW          = (RD_WAIT_CYC > 1) ? $clog2(RD_WAIT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST    = CW'(RD_WAIT_CYC - 1);
    localparam logic [15:0]   N16         = 16'(N);
    localparam logic [16:0]   N17         = 17'(N);
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WR_PULSE, WR_RESP, RD_WAIT, RD_RESP} state_e;

    state_e        state_q, state_d;
    logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic [15:0]   s_addr_q, s_addr_d, d_addr_q, d_addr_d;
    logic [31:0]   col_wdata_q, col_wdata_d, rdata_q, rdata_d, rd_sel;
    logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
    logic          arready_gated, aw_fire, w_fire, ar_fire, rd_last, legal;
    logic [16:0]   k_raw, k_col;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^{axi.s_axi_awaddr[1:0], axi.s_axi_araddr[1:0]};

    // Column index (d - s - 1) mod N, biased by N so the dividend stays non-negative.
    assign legal = (s_addr_q < N16) && (d_addr_q < N16) && (s_addr_q != d_addr_q);
    assign k_raw = {1'b0, d_addr_q} + N17 - {1'b0, s_addr_q} - 17'd1;
    assign k_col = k_raw % N17;

    // Any pending write-channel valid holds off AR, so a simultaneous write wins.
    assign arready_gated = arready_q && !axi.s_axi_awvalid && !axi.s_axi_wvalid;
    assign aw_fire       = axi.s_axi_awvalid && awready_q;
    assign w_fire        = axi.s_axi_wvalid && wready_q;
    assign ar_fire       = axi.s_axi_arvalid && arready_gated;
    assign rd_last       = (state_q == RD_WAIT) && (cnt_q == CNT_LAST);

`ifdef WEIGHT_READBACK_EN
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (k_col == 17'(i)) rd_sel = col_rdata[32*i +: 32];
        end
    end
`else
    logic unused_col_rdata;
    assign unused_col_rdata = ^col_rdata;
    assign rd_sel = '0;
`endif

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_q   <= IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                aw_held_d = aw_held_q || aw_fire;
                w_held_d  = w_held_q || w_fire;
                if (aw_held_d && w_held_d) begin
                    state_d   = WR_PULSE;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end else if (ar_fire) begin
                    state_d = RD_WAIT;
                    cnt_d   = '0;
                end
            end
            WR_PULSE: state_d = WR_RESP;
            WR_RESP:  if (axi.s_axi_bready) state_d = IDLE;
            RD_WAIT:  if (rd_last) state_d = RD_RESP;
                      else         cnt_d   = cnt_q + CW'(1);
            RD_RESP:  if (axi.s_axi_rready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        col_wready   = 1'b0;
        col_wr_match = '0;
        if (state_q == WR_PULSE && legal) begin
            col_wready = 1'b1;
            for (int i = 0; i < NUM_COLS; i++) col_wr_match[i] = (k_col == 17'(i));
        end
        axi.s_axi_awready = awready_q;
        axi.s_axi_wready  = wready_q;
        axi.s_axi_arready = arready_gated;
        axi.s_axi_bvalid  = (state_q == WR_RESP);
        axi.s_axi_bresp   = bresp_q;
        axi.s_axi_rvalid  = (state_q == RD_RESP);
        axi.s_axi_rdata   = rdata_q;
        axi.s_axi_rresp   = rresp_q;
    end

    always_comb begin
        s_addr_d    = s_addr_q;
        d_addr_d    = d_addr_q;
        col_wdata_d = col_wdata_q;
        bresp_d     = bresp_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        if (aw_fire) begin
            s_addr_d = axi.s_axi_awaddr[31:16];
            d_addr_d = {2'b00, axi.s_axi_awaddr[15:2]};
        end else if (ar_fire) begin
            s_addr_d = axi.s_axi_araddr[31:16];
            d_addr_d = {2'b00, axi.s_axi_araddr[15:2]};
        end
        if (w_fire) col_wdata_d = axi.s_axi_wdata;
        if (state_q == WR_PULSE) bresp_d = legal ? RESP_OKAY : RESP_SLVERR;
        if (rd_last) begin
            rdata_d = legal ? rd_sel : '0;
            rresp_d = legal ? RESP_OKAY : RESP_SLVERR;
        end
        awready_d = (state_d == IDLE) && !aw_held_d;
        wready_d  = (state_d == IDLE) && !w_held_d;
        arready_d = (state_d == IDLE) && !aw_held_d && !w_held_d;
    end

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            arready_q   <= 1'b0;
            s_addr_q    <= '0;
            d_addr_q    <= '0;
            col_wdata_q <= '0;
            bresp_q     <= '0;
            rdata_q     <= '0;
            rresp_q     <= '0;
        end else begin
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            arready_q   <= arready_d;
            s_addr_q    <= s_addr_d;
            d_addr_q    <= d_addr_d;
            col_wdata_q <= col_wdata_d;
            bresp_q     <= bresp_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
        end
    end

    assign s_addr    = s_addr_q;
    assign d_addr    = d_addr_q;
    assign col_wdata = col_wdata_q;
endmodule
